// File: rtl/output_layer_argmax.sv
// Output layer of the digit classifier: one time-multiplexed MAC streams weights from a
// synchronous ROM, saturates each neuron score and tracks the argmax class.
module output_layer_argmax #(
    parameter int unsigned N_IN   = 10,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned ADDR_W = $clog2(N_IN * N_OUT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_IN-1:0][DATA_W-1:0]  hidden_relu_out,
    input  logic [N_IN-1:0]              hidden_relu_valid,
    input  logic [N_OUT-1:0][DATA_W-1:0] biases_out,
    output logic                         weight_rd_en,
    output logic [ADDR_W-1:0]            weight_addr,
    input  logic [DATA_W-1:0]            weight_data,
    output logic                         in_ready,
    output logic                         frame_dropped,
    output logic [N_OUT-1:0][DATA_W-1:0] out_scores,
    output logic [3:0]                   out_class,
    output logic                         out_valid
);

    localparam int unsigned IN_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN * N_OUT - 1);
    localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                         state_q, state_d;
    logic                           all_valid_q;
    logic [N_IN-1:0][DATA_W-1:0]    act_q, act_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [IN_W-1:0]                in_idx_q, in_idx_d;
    logic [OUT_W-1:0]               out_idx_q, out_idx_d;
    logic                           rd_vld_q;
    logic [IN_W-1:0]                rd_in_q;
    logic [OUT_W-1:0]               rd_out_q;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [N_OUT-1:0][DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]              max_q, max_d;
    logic [OUT_W-1:0]               cls_q, cls_d;
    logic [N_OUT-1:0][DATA_W-1:0]   out_scores_q, out_scores_d;
    logic [3:0]                     out_class_q, out_class_d;
    logic                           out_valid_d, frame_dropped_d;
    logic                           out_valid_q, frame_dropped_q;

    logic                           all_valid, frame_arrive;
    logic [DATA_W-1:0]              act_sel, bias_sel;
    logic signed [2*DATA_W-1:0]     prod;
    logic signed [ACC_W-1:0]        seed, acc_sum, score_full;
    logic [DATA_W-1:0]              score_sat;

    assign all_valid    = &hidden_relu_valid;
    assign frame_arrive = all_valid & ~all_valid_q;

    assign weight_rd_en  = (state_q == StRun);
    assign weight_addr   = addr_q;
    assign in_ready      = (state_q == StIdle);
    assign frame_dropped = frame_dropped_q;
    assign out_scores    = out_scores_q;
    assign out_class     = out_class_q;
    assign out_valid     = out_valid_q;

    // Datapath for the word returned this cycle (issued one cycle earlier).
    always_comb begin
        act_sel    = act_q[rd_in_q];
        bias_sel   = biases_out[rd_out_q];
        prod       = $signed(act_sel) * $signed(weight_data);
        seed       = ACC_W'($signed(bias_sel)) <<< FRAC_W;
        acc_sum    = ((rd_in_q == '0) ? seed : acc_q) + ACC_W'(prod);
        score_full = acc_sum >>> FRAC_W;
        if (score_full > SAT_MAX) begin
            score_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (score_full < SAT_MIN) begin
            score_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            score_sat = score_full[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d         = state_q;
        act_d           = act_q;
        addr_d          = addr_q;
        in_idx_d        = in_idx_q;
        out_idx_d       = out_idx_q;
        acc_d           = acc_q;
        shadow_d        = shadow_q;
        max_d           = max_q;
        cls_d           = cls_q;
        out_scores_d    = out_scores_q;
        out_class_d     = out_class_q;
        out_valid_d     = 1'b0;
        frame_dropped_d = frame_arrive && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (frame_arrive) begin
                    act_d     = hidden_relu_out;
                    addr_d    = '0;
                    in_idx_d  = '0;
                    out_idx_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                addr_d = addr_q + 1'b1;
                if (in_idx_q == IN_LAST) begin
                    in_idx_d  = '0;
                    out_idx_d = out_idx_q + 1'b1;
                end else begin
                    in_idx_d = in_idx_q + 1'b1;
                end
                if (addr_q == LAST_ADDR) begin
                    addr_d    = '0;
                    out_idx_d = '0;
                    state_d   = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                out_scores_d = shadow_q;
                out_class_d  = 4'(cls_q);
                out_valid_d  = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rd_vld_q) begin
            acc_d = acc_sum;
            if (rd_in_q == IN_LAST) begin
                shadow_d[rd_out_q] = score_sat;
                // Strictly greater keeps the lowest index on ties.
                if (rd_out_q == '0 || $signed(score_sat) > $signed(max_q)) begin
                    max_d = score_sat;
                    cls_d = rd_out_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            all_valid_q     <= 1'b0;
            act_q           <= '0;
            addr_q          <= '0;
            in_idx_q        <= '0;
            out_idx_q       <= '0;
            rd_vld_q        <= 1'b0;
            rd_in_q         <= '0;
            rd_out_q        <= '0;
            acc_q           <= '0;
            shadow_q        <= '0;
            max_q           <= '0;
            cls_q           <= '0;
            out_scores_q    <= '0;
            out_class_q     <= '0;
            out_valid_q     <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            all_valid_q     <= all_valid;
            act_q           <= act_d;
            addr_q          <= addr_d;
            in_idx_q        <= in_idx_d;
            out_idx_q       <= out_idx_d;
            rd_vld_q        <= weight_rd_en;
            rd_in_q         <= in_idx_q;
            rd_out_q        <= out_idx_q;
            acc_q           <= acc_d;
            shadow_q        <= shadow_d;
            max_q           <= max_d;
            cls_q           <= cls_d;
            out_scores_q    <= out_scores_d;
            out_class_q     <= out_class_d;
            out_valid_q     <= out_valid_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

endmodule
